// File: rtl/fir_frame_packer_if.sv
// fir_frame_packer_if
//   Bundles the serial sample intake and the parallel frame output of the
//   frame packer.
//   master : packer side (drives in_tready, m_tvalid, m_tdata)
//   slave  : environment side (drives in_tvalid/in_tdata/in_tlast, m_tready)
//   in_*   : serial channel-interleaved samples, in_tlast on channel CHANNELS-1
//   m_*    : one assembled frame per beat, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
interface fir_frame_packer_if #(
  parameter int CHANNELS   = 16,
  parameter int DATA_WIDTH = 16
);
  logic                           in_tvalid;
  logic                           in_tready;
  logic [DATA_WIDTH-1:0]          in_tdata;
  logic                           in_tlast;
  logic                           m_tvalid;
  logic                           m_tready;
  logic [CHANNELS*DATA_WIDTH-1:0] m_tdata;

  modport master (
    input  in_tvalid, in_tdata, in_tlast, m_tready,
    output in_tready, m_tvalid, m_tdata
  );

  modport slave (
    output in_tvalid, in_tdata, in_tlast, m_tready,
    input  in_tready, m_tvalid, m_tdata
  );
endinterface

// File: rtl/fir_frame_packer.sv
// fir_frame_packer
//   Packs a serial, channel-interleaved sample stream into parallel frames for
//   the multichannel FIR decimator. Double-buffered: an assembly register keeps
//   taking samples while a finished frame waits in the output register.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   bus       : fir_frame_packer_if.master (serial intake + frame output)
//   err_pulse : one-cycle pulse on a framing error (early or missing tlast)
//   err_count : saturating framing-error count
module fir_frame_packer #(
  parameter int CHANNELS   = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_frame_packer_if.master   bus,
  output logic                 err_pulse,
  output logic [15:0]          err_count
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(CHANNELS - 1);

  typedef logic [CHANNELS-1:0][DATA_WIDTH-1:0] frame_t;

  frame_t        r_asm;
  frame_t        r_out;
  frame_t        w_frame;
  logic [CW-1:0] r_ch_idx;
  logic          r_asm_full;
  logic          r_m_tvalid;
  logic          r_err_pulse;
  logic [15:0]   r_err_count;

  logic w_in_fire, w_out_free, w_last_slot, w_complete, w_early, w_missing;

  // in_tready depends on registered state only
  assign bus.in_tready = !r_asm_full;
  assign bus.m_tvalid  = r_m_tvalid;
  assign bus.m_tdata   = r_out;
  assign err_pulse     = r_err_pulse;
  assign err_count     = r_err_count;

  assign w_in_fire   = bus.in_tvalid && !r_asm_full;
  assign w_out_free  = !r_m_tvalid || bus.m_tready;
  assign w_last_slot = (r_ch_idx == LAST_IDX);
  assign w_complete  = w_in_fire && w_last_slot;
  assign w_early     = w_in_fire && bus.in_tlast && !w_last_slot;
  assign w_missing   = w_in_fire && !bus.in_tlast && w_last_slot;

  // Assembly contents including the beat being accepted this cycle, so a
  // completing frame can go straight to the output register.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    assign w_frame[k] = (w_in_fire && (r_ch_idx == CW'(k))) ? bus.in_tdata : r_asm[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asm       <= '0;
      r_out       <= '0;
      r_ch_idx    <= '0;
      r_asm_full  <= 1'b0;
      r_m_tvalid  <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      // Intake: early tlast discards the partial frame by restarting at slot 0;
      // stale slots get overwritten by the next frame.
      if (w_in_fire) begin
        r_asm    <= w_frame;
        r_ch_idx <= (w_last_slot || bus.in_tlast) ? '0 : r_ch_idx + CW'(1);
      end

      // Output register. A pending frame has priority; while it is pending no
      // beat is accepted, so the two load sources never collide.
      if (r_asm_full && w_out_free) begin
        r_out      <= r_asm;
        r_m_tvalid <= 1'b1;
        r_asm_full <= 1'b0;
      end else if (w_complete && w_out_free) begin
        r_out      <= w_frame;
        r_m_tvalid <= 1'b1;
      end else begin
        if (w_complete)
          r_asm_full <= 1'b1;
        if (r_m_tvalid && bus.m_tready)
          r_m_tvalid <= 1'b0;
      end

      r_err_pulse <= w_early || w_missing;
      if ((w_early || w_missing) && (r_err_count != 16'hFFFF))
        r_err_count <= r_err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fir_frame_packer.sv
module tb_fir_frame_packer;
  localparam int CH = 16;
  localparam int DW = 16;
  localparam int FW = CH * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          err_pulse;
  logic [15:0]   err_count;

  always #5 clk = ~clk;

  fir_frame_packer_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) bus ();

  fir_frame_packer #(.CHANNELS(CH), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int notready_cnt = 0;
  logic [FW-1:0] exp_q[$];
  int xfer_cyc[$];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic chkf(input string n, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] ramp();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < CH; k++) f[k*DW +: DW] = DW'(k + 1);
    return f;
  endfunction

  // drive one beat and wait (bounded) until it is accepted
  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int t;
    t = 0;
    bus.in_tvalid = 1'b1;
    bus.in_tdata  = d;
    bus.in_tlast  = l;
    @(negedge clk);
    while (!bus.in_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_tready) begin
      checks++;
      failures++;
      $display("FAIL beat_accept_timeout got=stalled exp=accepted");
    end
    @(posedge clk);
    #1;
    bus.in_tvalid = 1'b0;
    bus.in_tlast  = 1'b0;
  endtask

  task automatic send_ramp(input logic miss_last);
    for (int k = 0; k < CH; k++)
      send_beat(DW'(k + 1), (k == CH - 1) && !miss_last);
  endtask

  task automatic do_reset();
    bus.in_tvalid = 1'b0;
    bus.in_tlast  = 1'b0;
    bus.in_tdata  = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chkf("rst_m_tdata", bus.m_tdata, '0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [FW-1:0] f, held;
    int p0;
    rst = 1'b1;
    bus.in_tvalid = 1'b0;
    bus.in_tdata  = '0;
    bus.in_tlast  = 1'b0;
    bus.m_tready  = 1'b1;
    fork
      // monitor: pops the scoreboard on every frame transfer
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst) begin
          if (err_pulse) pulse_cnt++;
          if (!bus.in_tready) notready_cnt++;
          if (bus.m_tvalid && bus.m_tready) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL frame_unexpected got=%h exp=none", bus.m_tdata);
            end else begin
              chkf("frame_data", bus.m_tdata, exp_q.pop_front());
            end
            xfer_cyc.push_back(cyc);
          end
        end
      end
      begin
        idle(2);
        do_reset();
        chk("rst_in_tready", 32'(bus.in_tready), 32'd1);

        // 1. impulse
        notready_cnt = 0;
        f = '0;
        f[15:0] = 16'h7FFF;
        exp_q.push_back(f);
        for (int k = 0; k < CH; k++) send_beat((k == 0) ? 16'h7FFF : 16'h0, k == CH - 1);
        chk("impulse_latency_valid", 32'(bus.m_tvalid), 32'd1);
        idle(3);
        chk("impulse_drop_valid", 32'(bus.m_tvalid), 32'd0);
        chk("impulse_in_tready_never_low", 32'(notready_cnt), 32'd0);

        // 2. ramp, four back-to-back frames
        xfer_cyc.delete();
        repeat (4) exp_q.push_back(ramp());
        repeat (4) send_ramp(1'b0);
        idle(3);
        chk("ramp_xfer_count", 32'(xfer_cyc.size()), 32'd4);
        for (int i = 1; i < 4 && i < xfer_cyc.size(); i++)
          chk("ramp_spacing", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'd16);
        chk("ramp_err_count", 32'(err_count), 32'd0);
        chk("ramp_in_tready_never_low", 32'(notready_cnt), 32'd0);

        // 3. backpressure
        bus.m_tready = 1'b0;
        exp_q.push_back(ramp());
        exp_q.push_back(ramp());
        send_ramp(1'b0);
        send_ramp(1'b0);
        chk("bp_in_tready_low", 32'(bus.in_tready), 32'd0);
        chk("bp_valid_held", 32'(bus.m_tvalid), 32'd1);
        chkf("bp_frame1_on_bus", bus.m_tdata, ramp());
        held = bus.m_tdata;
        idle(3);
        chkf("bp_frame1_stable", bus.m_tdata, held);
        chk("bp_valid_stable", 32'(bus.m_tvalid), 32'd1);
        xfer_cyc.delete();
        bus.m_tready = 1'b1;
        @(negedge clk);
        chk("bp_in_tready_while_frame1", 32'(bus.in_tready), 32'd0);
        @(negedge clk);
        chk("bp_in_tready_after_frame2_load", 32'(bus.in_tready), 32'd1);
        idle(2);
        chk("bp_xfer_count", 32'(xfer_cyc.size()), 32'd2);
        if (xfer_cyc.size() == 2)
          chk("bp_consecutive", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd1);

        // 4. early tlast at beat index 5
        do_reset();
        p0 = pulse_cnt;
        for (int k = 0; k < 6; k++) send_beat(DW'(k + 100), k == 5);
        idle(3);
        chk("early_err_count", 32'(err_count), 32'd1);
        chk("early_pulse_cycles", 32'(pulse_cnt - p0), 32'd1);
        chk("early_no_valid", 32'(bus.m_tvalid), 32'd0);
        exp_q.push_back(ramp());
        send_ramp(1'b0);
        idle(3);
        chk("early_realign_err_count", 32'(err_count), 32'd1);

        // 5. missing tlast
        do_reset();
        p0 = pulse_cnt;
        exp_q.push_back(ramp());
        send_ramp(1'b1);
        idle(3);
        chk("miss_err_count", 32'(err_count), 32'd1);
        chk("miss_pulse_cycles", 32'(pulse_cnt - p0), 32'd1);
        chk("miss_frame_out", 32'(exp_q.size()), 32'd0);

        // 6. reset mid-frame
        do_reset();
        for (int k = 0; k < 7; k++) send_beat(DW'(k + 50), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(ramp());
        send_ramp(1'b0);
        idle(3);
        chk("midrst_err_after", 32'(err_count), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
